// File: rtl/ps2_receiver_if.sv
// PS/2 receiver bundle: raw PS/2 lines in, decoded byte and status strobes out.
// The device side drives the lines; the receiver side produces the results.
interface ps2_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       parity_error;
  logic       frame_error;
  logic       busy;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  scan_code,
    input  scan_code_ready,
    input  parity_error,
    input  frame_error,
    input  busy
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output scan_code,
    output scan_code_ready,
    output parity_error,
    output frame_error,
    output busy
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the PS/2 clock,
// shifts in start/8 data/odd parity/stop, and reports each frame with a one-cycle strobe.
module ps2_receiver #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input logic           sys_clk,
  input logic           reset,
  ps2_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0]  FLT_LAST = 8'(FILTER_LEN - 1);
  // Strobes are registered, so the watchdog fires one cycle early to make
  // frame_error visible exactly TIMEOUT cycles after the last fall strobe.
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 2);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       filt_q;
  logic       filt_prev_q;
  logic [7:0] flt_cnt_q;
  logic       fall;
  logic       sdata;
  logic [15:0] wd_q;
  logic       timeout;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       par_q, par_d;
  logic [7:0] code_q, code_d;
  logic       ready_q, ready_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       busy_q;

  // Both raw lines idle high, so the synchronizers reset to 1.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
    end
  end

  assign sdata = data_sync[1];

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_sync[1] == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        filt_q    <= clk_sync[1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 8'd1;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  always_ff @(posedge sys_clk) begin
    if (reset || fall || (state_q == IDLE)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 16'd1;
    end
  end

  assign timeout = (state_q != IDLE) && !fall && (wd_q == WD_LAST);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      code_q    <= '0;
      ready_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      code_q    <= code_d;
      ready_q   <= ready_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    code_d    = code_q;
    ready_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (timeout) begin
      // A stalled frame is dropped; the partial byte never reaches scan_code.
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall && !sdata) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        DATA: begin
          if (fall) begin
            shift_d = {sdata, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_d = PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            par_d   = sdata;
            state_d = STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state_d = IDLE;
            if (!sdata) begin
              ferr_d = 1'b1;
            end else if (^{shift_q, par_q}) begin
              ready_d = 1'b1;
              code_d  = shift_q;
            end else begin
              perr_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.scan_code       = code_q;
  assign bus.scan_code_ready = ready_q;
  assign bus.parity_error    = perr_q;
  assign bus.frame_error     = ferr_q;
  assign bus.busy            = busy_q;

  a_strobe_onehot: assert property (@(posedge sys_clk) disable iff (reset)
    $onehot0({ready_q, perr_q, ferr_q}));

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: drives PS/2 frames, queues the expected strobe,
// byte and arrival cycle, and a negedge monitor pops and compares on every strobe.
module tb_ps2_receiver;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 300;
  localparam int HALF       = 40;
  localparam int K_READY = 0, K_PERR = 1, K_FERR = 2, K_NONE = 3;

  typedef struct {
    int kind;
    int code;
    int at;
  } exp_t;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  exp_t sbq[$];
  logic prev_strobe = 1'b0;
  int   last_fall;

  ps2_receiver_if bus ();

  ps2_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
               name, act, act, exp_v, exp_v, cyc);
    end
  endtask

  always @(negedge sys_clk) begin
    automatic int n = int'(bus.scan_code_ready) + int'(bus.parity_error) + int'(bus.frame_error);
    automatic int k;
    automatic exp_t e;
    if (n != 0) begin
      check("strobe_onehot", n, 1);
      check("strobe_width", int'(prev_strobe), 0);
      k = bus.scan_code_ready ? K_READY : (bus.parity_error ? K_PERR : K_FERR);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got kind=%0d scan_code=0x%02h at cycle %0d, want no strobe",
                 k, bus.scan_code, cyc);
      end else begin
        e = sbq.pop_front();
        check("strobe_kind", k, e.kind);
        check("scan_code", int'(bus.scan_code), e.code);
        check("strobe_cycle", cyc, e.at);
      end
    end
    prev_strobe = (n != 0);
  end

  // Sends the first nbits of {stop, parity, data, start}; optional short glitches
  // in both clock phases. The stop-bit fall queues the expected response.
  task automatic send(input logic [7:0] d, input logic p, input logic s, input int nbits,
                      input bit glitch, input int kind, input int code);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = f[i];
      if (glitch) begin
        repeat (10) @(negedge sys_clk);
        bus.ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge sys_clk);
        bus.ps2_clk = 1'b1;
        repeat (HALF - 10 - (FILTER_LEN - 1)) @(negedge sys_clk);
      end else begin
        repeat (HALF) @(negedge sys_clk);
      end
      bus.ps2_clk = 1'b0;
      last_fall = cyc;
      if (i == 10 && kind != K_NONE) sbq.push_back('{kind, code, cyc + FILTER_LEN + 3});
      if (glitch) begin
        repeat (12) @(negedge sys_clk);
        bus.ps2_clk = 1'b1;
        repeat (FILTER_LEN - 1) @(negedge sys_clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF - 12 - (FILTER_LEN - 1)) @(negedge sys_clk);
      end else begin
        repeat (HALF) @(negedge sys_clk);
      end
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.ps2_data = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scan_code"}, int'(bus.scan_code), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_ready"}, int'(bus.scan_code_ready), 0);
    check({tag, "_perr"}, int'(bus.parity_error), 0);
    check({tag, "_ferr"}, int'(bus.frame_error), 0);
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge sys_clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(20);

    // Single good frame 0x1C, parity 0
    send(8'h1C, 1'b0, 1'b1, 11, 1'b0, K_READY, 8'h1C);
    idle(2 * HALF);
    check("busy_after_1C", int'(bus.busy), 0);

    // Back-to-back 0xF0 (parity 1) and 0x1C (parity 0)
    send(8'hF0, 1'b1, 1'b1, 11, 1'b0, K_READY, 8'hF0);
    send(8'h1C, 1'b0, 1'b1, 11, 1'b0, K_READY, 8'h1C);
    idle(2 * HALF);

    // 0xE0 needs parity 0; parity 1 is rejected, scan_code stays 0x1C
    send(8'hE0, 1'b1, 1'b1, 11, 1'b0, K_PERR, 8'h1C);
    idle(2 * HALF);

    // Bad stop bit, then the same byte framed correctly
    send(8'h29, 1'b0, 1'b0, 11, 1'b0, K_FERR, 8'h1C);
    idle(2 * HALF);
    send(8'h29, 1'b0, 1'b1, 11, 1'b0, K_READY, 8'h29);
    idle(2 * HALF);

    // Start + 4 data bits, then the clock stalls high
    send(8'h0F, 1'b0, 1'b1, 5, 1'b0, K_NONE, 0);
    check("busy_mid_frame", int'(bus.busy), 1);
    sbq.push_back('{K_FERR, 8'h29, last_fall + FILTER_LEN + 2 + TIMEOUT});
    idle(TIMEOUT + 10);
    check("busy_after_timeout", int'(bus.busy), 0);
    check("scan_code_after_timeout", int'(bus.scan_code), 8'h29);
    send(8'h5A, 1'b1, 1'b1, 11, 1'b0, K_READY, 8'h5A);
    idle(2 * HALF);

    // Sub-threshold glitches in every clock phase
    send(8'h75, 1'b0, 1'b1, 11, 1'b1, K_READY, 8'h75);
    idle(2 * HALF);
    check("scan_code_after_glitch", int'(bus.scan_code), 8'h75);

    // Reset in the middle of a frame
    send(8'hAA, 1'b0, 1'b1, 6, 1'b0, K_NONE, 0);
    check("busy_before_reset", int'(bus.busy), 1);
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    check_reset_outputs("midreset");
    idle(TIMEOUT + 20);
    check_reset_outputs("post_reset_idle");
    send(8'h1C, 1'b0, 1'b1, 11, 1'b0, K_READY, 8'h1C);
    idle(2 * HALF);

    for (int i = 0; i < 2000 && sbq.size() != 0; i++) @(negedge sys_clk);
    while (sbq.size() != 0) begin
      automatic exp_t e = sbq.pop_front();
      total++;
      bad++;
      $display("FAIL missing_strobe: got none, want kind=%0d scan_code=0x%02h at cycle %0d",
               e.kind, e.code, e.at);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter FILTER_LEN, 8: consecutive equal samples of synchronized ps2_clk needed to change its filtered level (range 2-255).
REQ-002 Parameter TIMEOUT, 50000: max sys_clk cycles between filtered ps2_clk falling edges inside a frame (16-bit).
REQ-003 sys_clk  input  1  system clock; single clock domain, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous.
REQ-007 scan_code  output  8  last correctly received byte; held until the next valid frame.
REQ-008 scan_code_ready  output  1  one-cycle strobe, scan_code valid and new.
REQ-009 parity_error  output  1  one-cycle strobe, frame rejected on parity.
REQ-010 frame_error  output  1  one-cycle strobe, bad stop bit or watchdog timeout.
REQ-011 busy  output  1  high while the FSM is not IDLE.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer before any use.
REQ-013 Filtered clock SHALL change level only after FILTER_LEN consecutive sys_clk samples differ from its current level; counter resets on any sample equal to current level.
REQ-014 Falling edge SHALL be a 1-to-0 transition of the filtered clock, producing a one-cycle internal fall strobe; synchronized ps2_data is sampled in that cycle.
REQ-015 FSM states: IDLE, DATA, PARITY, STOP; transitions occur only on fall strobes or timeout.
REQ-016 IDLE: fall with data=0 (start) -> DATA, bit counter=0; fall with data=1 -> stay IDLE, no error.
REQ-017 DATA: shift sampled bit into shift register LSB first; after 8th bit -> PARITY.
REQ-018 PARITY: capture bit -> STOP; parity is odd (8 data bits + parity bit contain an odd number of ones).
REQ-019 STOP: on fall -> IDLE; if stop=1 and parity good, load scan_code and pulse scan_code_ready next cycle; if stop=1 and parity bad, pulse parity_error only; if stop=0, pulse frame_error only (overrides parity).
REQ-020 Latency: scan_code_ready and scan_code update SHALL appear exactly 1 cycle after the stop-bit fall strobe.
REQ-021 Watchdog counter SHALL clear on every fall strobe and in IDLE; increments otherwise; reaching TIMEOUT in DATA/PARITY/STOP -> IDLE, pulse frame_error, partial byte discarded, scan_code unchanged.
REQ-022 Strobes SHALL never be high for more than one consecutive cycle and at most one of scan_code_ready, parity_error, frame_error is high per cycle.
REQ-023 No back-pressure: downstream decoder samples the strobe level; a new valid frame overwrites scan_code unconditionally.
REQ-024 Rejected frames SHALL leave scan_code unchanged.
REQ-025 busy = (state != IDLE), registered with the state.

Reset
REQ-026 reset SHALL force IDLE, scan_code=8'h00, all strobes=0, busy=0, shift register and counters=0, filtered clock and synchronizer flops=1 (idle line).
REQ-027 reset asserted mid-frame SHALL discard the frame with no strobe; the first fall after release is treated as a possible start bit.

Verification
REQ-028 Frame 0x1C, parity 0, stop 1, 80 us bit period -> single scan_code_ready pulse, scan_code=8'h1C, busy low after.
REQ-029 Frames 0xF0 (parity 1) then 0x1C (parity 0) back-to-back -> two ready pulses, scan_code sequence F0, 1C, no errors.
REQ-030 Frame 0xE0 with parity 1 (wrong) -> parity_error pulse, no ready, scan_code keeps previous value.
REQ-031 Frame 0x29 with stop=0 -> frame_error pulse only; next good 0x29 frame accepted.
REQ-032 Stop ps2_clk after 4 data bits for TIMEOUT+10 cycles -> frame_error exactly TIMEOUT cycles after last fall, busy drops, following full frame 0x5A received correctly.
REQ-033 Glitches of FILTER_LEN-1 cycles on ps2_clk during a 0x75 frame -> no extra bits, scan_code=8'h75; reset pulse mid-frame -> no strobe, outputs at reset values.
